// File: rtl/sky130_fd_io__xres_filt_nch.sv
// Multi-channel XRES reset filter.
// Each channel muxes its source, synchronises it and deglitches it. The
// channels are then combined into one stretched active-low reset.
module sky130_fd_io__xres_filt_nch #(
  parameter int NCH         = 4,
  parameter int CNT_W       = 8,
  parameter int SYNC_STAGES = 2,
  parameter int STRETCH     = 16,
  parameter int STRETCH_W   = 5
) (
  input  logic             CLK,
  input  logic             RST_H,
  input  logic [NCH-1:0]   PAD,
  input  logic [NCH-1:0]   FILT_IN_H,
  input  logic [NCH-1:0]   INP_SEL_H,
  input  logic [NCH-1:0]   ENABLE_H,
  input  logic [CNT_W-1:0] FILT_LEN_H,
  input  logic             CLR_FLAG_H,
  output logic [NCH-1:0]   XRES_H_N,
  output logic [NCH-1:0]   SHORT_PULSE_H,
  output logic             XRES_ALL_H_N
);

  typedef enum logic {IDLE = 1'b0, QUAL = 1'b1} ch_st_e;

  localparam logic [STRETCH_W-1:0] STRETCH_INIT = STRETCH_W'(STRETCH);

  logic [NCH-1:0]   src_w;
  logic [CNT_W-1:0] len_w;

  // Disabled channels read as released. The mux sits ahead of the
  // synchroniser, so enable/select changes are deglitched like pad data.
  assign src_w = ~ENABLE_H | (INP_SEL_H & FILT_IN_H) | (~INP_SEL_H & PAD);
  // A programmed length of 0 behaves as 1.
  assign len_w = (FILT_LEN_H == '0) ? CNT_W'(1) : FILT_LEN_H;

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s_w;
    ch_st_e                 st_q, st_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [CNT_W:0]         cnt_inc;
    logic                   xres_q, xres_d;
    logic                   flag_q, flag_d, flag_set;

    assign s_w     = sync_q[SYNC_STAGES-1];
    // cnt_q holds mismatched samples already seen; cnt_inc includes the
    // current one, so a change held for L samples toggles on the L-th.
    assign cnt_inc = {1'b0, cnt_q} + (CNT_W+1)'(1);

    // Synchroniser shift chain for the muxed source.
    always_ff @(posedge CLK or posedge RST_H) begin
      if (RST_H) sync_q <= '0;
      else       sync_q <= {sync_q[SYNC_STAGES-2:0], src_w[i]};
    end

    // Deglitch next-state: qualify a mismatch for L samples, flag early ends.
    always_comb begin
      st_d     = st_q;
      cnt_d    = cnt_q;
      xres_d   = xres_q;
      flag_set = 1'b0;
      if (s_w != xres_q) begin
        if (cnt_inc >= {1'b0, len_w}) begin
          xres_d = s_w;
          cnt_d  = '0;
          st_d   = IDLE;
        end else begin
          st_d  = QUAL;
          cnt_d = (&cnt_q) ? cnt_q : cnt_inc[CNT_W-1:0];
        end
      end else begin
        if (st_q == QUAL) flag_set = 1'b1;
        st_d  = IDLE;
        cnt_d = '0;
      end
      // A new rejection wins over a simultaneous clear.
      flag_d = flag_set | (flag_q & ~CLR_FLAG_H);
    end

    // Channel state registers.
    always_ff @(posedge CLK or posedge RST_H) begin
      if (RST_H) begin
        st_q   <= IDLE;
        cnt_q  <= '0;
        xres_q <= 1'b0;
        flag_q <= 1'b0;
      end else begin
        st_q   <= st_d;
        cnt_q  <= cnt_d;
        xres_q <= xres_d;
        flag_q <= flag_d;
      end
    end

    assign XRES_H_N[i]      = xres_q;
    assign SHORT_PULSE_H[i] = flag_q;
  end

  logic [STRETCH_W-1:0] str_q, str_d;
  logic                 all_q, all_d;

  // Combined reset: any low channel reloads the stretch, release after it drains.
  always_comb begin
    str_d = str_q;
    all_d = all_q;
    if (!(&XRES_H_N)) begin
      str_d = STRETCH_INIT;
      all_d = 1'b0;
    end else if (str_q != '0) begin
      str_d = str_q - STRETCH_W'(1);
      all_d = 1'b0;
    end else begin
      all_d = 1'b1;
    end
  end

  // Combined reset registers.
  always_ff @(posedge CLK or posedge RST_H) begin
    if (RST_H) begin
      str_q <= STRETCH_INIT;
      all_q <= 1'b0;
    end else begin
      str_q <= str_d;
      all_q <= all_d;
    end
  end

  assign XRES_ALL_H_N = all_q;

endmodule

// File: tb/tb_sky130_fd_io__xres_filt_nch.sv
// Directed bench for the XRES filter with a run-length reference model.
module tb_sky130_fd_io__xres_filt_nch;
  localparam int NCH = 4, CNT_W = 8, SYNC = 2, STRETCH = 16, STRETCH_W = 5;

  logic             CLK = 1'b0;
  logic             RST_H = 1'b1;
  logic [NCH-1:0]   PAD = '1, FILT_IN_H = '1, INP_SEL_H = '0, ENABLE_H = '1;
  logic [CNT_W-1:0] FILT_LEN_H = 8'd4;
  logic             CLR_FLAG_H = 1'b0;
  logic [NCH-1:0]   XRES_H_N, SHORT_PULSE_H;
  logic             XRES_ALL_H_N;

  sky130_fd_io__xres_filt_nch #(
    .NCH(NCH), .CNT_W(CNT_W), .SYNC_STAGES(SYNC), .STRETCH(STRETCH), .STRETCH_W(STRETCH_W)
  ) dut (
    .CLK(CLK), .RST_H(RST_H), .PAD(PAD), .FILT_IN_H(FILT_IN_H), .INP_SEL_H(INP_SEL_H),
    .ENABLE_H(ENABLE_H), .FILT_LEN_H(FILT_LEN_H), .CLR_FLAG_H(CLR_FLAG_H),
    .XRES_H_N(XRES_H_N), .SHORT_PULSE_H(SHORT_PULSE_H), .XRES_ALL_H_N(XRES_ALL_H_N)
  );

  always #5 CLK = ~CLK;

  int nchk = 0, nerr = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: the synchroniser is a lookup into a per-edge history of
  // the source, the filter is a run length of disagreeing samples, and the
  // combined reset counts consecutive edges with every channel released.
  logic [NCH-1:0] m_out, m_flg;
  int             m_run [NCH];
  int             m_hi, m_n;
  logic [NCH-1:0] m_hist [0:1023];

  always @(posedge CLK or posedge RST_H) begin : model
    logic [NCH-1:0] src, sv, o, f;
    int r [NCH];
    int len, n;
    if (RST_H) begin
      m_out <= '0;
      m_flg <= '0;
      m_hi  <= 0;
      m_n   <= 0;
      for (int i = 0; i < NCH; i++) m_run[i] <= 0;
    end else begin
      n   = m_n + 1;
      for (int i = 0; i < NCH; i++)
        src[i] = ENABLE_H[i] ? (INP_SEL_H[i] ? FILT_IN_H[i] : PAD[i]) : 1'b1;
      sv  = (n > SYNC) ? m_hist[(n - SYNC) % 1024] : '0;
      len = (FILT_LEN_H == 0) ? 1 : int'(FILT_LEN_H);
      o   = m_out;
      f   = CLR_FLAG_H ? '0 : m_flg;
      for (int i = 0; i < NCH; i++) begin
        r[i] = m_run[i];
        if (sv[i] != o[i]) begin
          r[i]++;
          if (r[i] >= len) begin
            o[i] = sv[i];
            r[i] = 0;
          end
        end else begin
          if (r[i] > 0) f[i] = 1'b1;
          r[i] = 0;
        end
      end
      m_hi <= (&m_out) ? m_hi + 1 : 0;
      m_hist[n % 1024] <= src;
      m_n   <= n;
      m_out <= o;
      m_flg <= f;
      for (int i = 0; i < NCH; i++) m_run[i] <= r[i];
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge CLK) begin
    if (chk_en) begin
      chk("model_xres", 32'(XRES_H_N), 32'(m_out));
      chk("model_flag", 32'(SHORT_PULSE_H), 32'(m_flg));
      chk("model_all", 32'(XRES_ALL_H_N), 32'(m_hi > STRETCH));
    end
  end

  task automatic step(input int k);
    repeat (k) @(negedge CLK);
  endtask

  initial begin
    step(2);
    chk_en = 1'b1;
    chk("rst_xres", 32'(XRES_H_N), 32'h0);
    chk("rst_flag", 32'(SHORT_PULSE_H), 32'h0);
    chk("rst_all", 32'(XRES_ALL_H_N), 32'h0);

    // Reset release, L=4: channels rise at edge 6, combined at edge 23.
    RST_H = 1'b0;
    step(5);  chk("rel_e5_xres", 32'(XRES_H_N), 32'h0);
    step(1);  chk("rel_e6_xres", 32'(XRES_H_N), 32'hF);
    step(16); chk("rel_e22_all", 32'(XRES_ALL_H_N), 32'h0);
    step(1);  chk("rel_e23_all", 32'(XRES_ALL_H_N), 32'h1);
    chk("rel_flag", 32'(SHORT_PULSE_H), 32'h0);

    // Ch0 3-cycle low pulse: rejected, flag at edge 6.
    PAD[0] = 1'b0; step(3); PAD[0] = 1'b1;
    step(2); chk("p0_e5_flag", 32'(SHORT_PULSE_H), 32'h0);
    step(1); chk("p0_e6_flag", 32'(SHORT_PULSE_H), 32'h1);
    chk("p0_e6_xres", 32'(XRES_H_N), 32'hF);
    CLR_FLAG_H = 1'b1; step(1); CLR_FLAG_H = 1'b0;
    chk("p0_clr", 32'(SHORT_PULSE_H), 32'h0);
    step(3);

    // Ch1 low for 10 cycles: low from edge 6 to 16, combined low 7..32.
    PAD[1] = 1'b0;
    step(5); chk("c1_e5_xres", 32'(XRES_H_N[1]), 32'h1);
    chk("c1_e5_all", 32'(XRES_ALL_H_N), 32'h1);
    step(1); chk("c1_e6_xres", 32'(XRES_H_N[1]), 32'h0);
    chk("c1_e6_all", 32'(XRES_ALL_H_N), 32'h1);
    step(1); chk("c1_e7_all", 32'(XRES_ALL_H_N), 32'h0);
    step(3); PAD[1] = 1'b1;
    step(5);  chk("c1_e15_xres", 32'(XRES_H_N[1]), 32'h0);
    step(1);  chk("c1_e16_xres", 32'(XRES_H_N[1]), 32'h1);
    step(16); chk("c1_e32_all", 32'(XRES_ALL_H_N), 32'h0);
    step(1);  chk("c1_e33_all", 32'(XRES_ALL_H_N), 32'h1);

    // Ch2 selects FILT_IN_H=0: falls at edge 6; disable: rises 6 edges later.
    INP_SEL_H[2] = 1'b1; FILT_IN_H[2] = 1'b0;
    step(5); chk("c2_e5_xres", 32'(XRES_H_N[2]), 32'h1);
    step(1); chk("c2_e6_xres", 32'(XRES_H_N[2]), 32'h0);
    ENABLE_H[2] = 1'b0;
    step(5); chk("c2_dis_e5", 32'(XRES_H_N[2]), 32'h0);
    step(1); chk("c2_dis_e6", 32'(XRES_H_N[2]), 32'h1);
    chk("c2_flag", 32'(SHORT_PULSE_H[2]), 32'h0);
    FILT_IN_H[2] = 1'b1; INP_SEL_H[2] = 1'b0; ENABLE_H[2] = 1'b1;
    step(20);

    // Clear in the same cycle the flag sets: set wins, next clear drops it.
    PAD[3] = 1'b0; step(3); PAD[3] = 1'b1;
    step(2); CLR_FLAG_H = 1'b1;
    step(1); chk("clr_same_flag", 32'(SHORT_PULSE_H), 32'h8);
    step(1); chk("clr_next_flag", 32'(SHORT_PULSE_H), 32'h0);
    CLR_FLAG_H = 1'b0;
    step(2);

    // FILT_LEN_H=0 behaves as L=1: latency 3 edges.
    FILT_LEN_H = 8'd0; PAD[3] = 1'b0;
    step(2); chk("l0_e2_xres", 32'(XRES_H_N[3]), 32'h1);
    step(1); chk("l0_e3_xres", 32'(XRES_H_N[3]), 32'h0);
    PAD[3] = 1'b1;
    step(3); chk("l0_rise_xres", 32'(XRES_H_N[3]), 32'h1);
    chk("l0_flag", 32'(SHORT_PULSE_H), 32'h0);
    FILT_LEN_H = 8'd4;
    step(20);

    // Reset mid-qualification: immediate clear, then a full restart.
    PAD[0] = 1'b0;
    step(4);
    #2 RST_H = 1'b1;
    #1;
    chk("amid_xres", 32'(XRES_H_N), 32'h0);
    chk("amid_flag", 32'(SHORT_PULSE_H), 32'h0);
    chk("amid_all", 32'(XRES_ALL_H_N), 32'h0);
    PAD[0] = 1'b1;
    step(1);
    RST_H = 1'b0;
    step(5);  chk("rr_e5_xres", 32'(XRES_H_N), 32'h0);
    step(1);  chk("rr_e6_xres", 32'(XRES_H_N), 32'hF);
    step(17); chk("rr_e23_all", 32'(XRES_ALL_H_N), 32'h1);
    chk("rr_flag", 32'(SHORT_PULSE_H), 32'h0);

    step(1);
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
